hazard_fwd_ctrl: RTL and testbench

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

---
 rtl/hazard_fwd_ctrl_if.sv | 38 +++
 rtl/hazard_fwd_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline-side bundle for hazard_fwd_ctrl: stage register indices, write/load flags,
// stall release/redirect inputs, and the forwarding/stall controls returned to the pipeline.
interface hazard_fwd_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_RegWEn;
    logic              ex_is_load;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_RegWEn;
    logic              mem_is_load;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_RegWEn;
    logic              load_done;
    logic              flush;
    logic [1:0]        ForwardSelA;
    logic [1:0]        ForwardSelB;
    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;

    modport master (
        output id_valid, id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_RegWEn, ex_is_load,
               mem_rd, mem_RegWEn, mem_is_load, wb_rd, wb_RegWEn, load_done, flush,
        input  ForwardSelA, ForwardSelB, stall_if, stall_id, bubble_ex
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_RegWEn, ex_is_load,
               mem_rd, mem_RegWEn, mem_is_load, wb_rd, wb_RegWEn, load_done, flush,
        output ForwardSelA, ForwardSelB, stall_if, stall_id, bubble_ex
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Operand forwarding select and load-use stall controller for a 5-stage pipeline.
// Optional macro HAZ_PERF_CNT_EN adds a saturating stall-cycle counter (stall_cycles, perf_clr).
module hazard_fwd_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hazard_fwd_ctrl_if.slave        hif
`ifdef HAZ_PERF_CNT_EN
    ,
    input  logic                    perf_clr,
    output logic [31:0]             stall_cycles
`endif
);
    localparam logic [REG_AW-1:0] ZERO_REG = '0;
    localparam logic [2:0]        WAIT_INIT = 3'(LOAD_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       detect;
    logic       stall_c;

    // MEM result wins over WB; a load in MEM has no data yet, so it cannot forward.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic              mem_we,
                                           input logic              mem_ld,
                                           input logic [REG_AW-1:0] mem_rd,
                                           input logic              wb_we,
                                           input logic [REG_AW-1:0] wb_rd);
        if (mem_we && !mem_ld && (mem_rd != ZERO_REG) && (mem_rd == rs))
            return 2'b10;
        else if (wb_we && (wb_rd != ZERO_REG) && (wb_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        hif.ForwardSelA = fwd_sel(hif.ex_rs1, hif.mem_RegWEn, hif.mem_is_load, hif.mem_rd,
                                  hif.wb_RegWEn, hif.wb_rd);
        hif.ForwardSelB = fwd_sel(hif.ex_rs2, hif.mem_RegWEn, hif.mem_is_load, hif.mem_rd,
                                  hif.wb_RegWEn, hif.wb_rd);
    end

    assign detect = hif.ex_is_load && hif.ex_RegWEn && (hif.ex_rd != ZERO_REG) && hif.id_valid &&
                    ((hif.id_rs1 == hif.ex_rd) || (hif.id_rs2 == hif.ex_rd));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                stall_c = detect && !hif.flush;
                if (detect && !hif.flush && (LOAD_LAT > 1)) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            WAIT: begin
                // Detect is not sampled here; the stalled instruction is already accounted for.
                stall_c = !hif.load_done && !hif.flush;
                cnt_d   = cnt_q - 3'd1;
                if ((cnt_q == 3'd1) || hif.load_done || hif.flush) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gate with rst_n so a live hazard on the inputs cannot stall while reset is held.
    always_comb begin
        hif.stall_if  = stall_c && rst_n;
        hif.stall_id  = stall_c && rst_n;
        hif.bubble_ex = stall_c && rst_n;
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (perf_clr)
            stall_cycles_d = 32'd0;
        else if (hif.stall_id && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles_q <= 32'd0;
        else
            stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: LOAD_LAT=3 instance (main) and LOAD_LAT=1 instance (no WAIT state).
module tb_hazard_fwd_ctrl;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl_if #(.REG_AW(AW)) if3 ();
    hazard_fwd_ctrl_if #(.REG_AW(AW)) if1 ();

    assign if1.id_valid    = if3.id_valid;
    assign if1.id_rs1      = if3.id_rs1;
    assign if1.id_rs2      = if3.id_rs2;
    assign if1.ex_rs1      = if3.ex_rs1;
    assign if1.ex_rs2      = if3.ex_rs2;
    assign if1.ex_rd       = if3.ex_rd;
    assign if1.ex_RegWEn   = if3.ex_RegWEn;
    assign if1.ex_is_load  = if3.ex_is_load;
    assign if1.mem_rd      = if3.mem_rd;
    assign if1.mem_RegWEn  = if3.mem_RegWEn;
    assign if1.mem_is_load = if3.mem_is_load;
    assign if1.wb_rd       = if3.wb_rd;
    assign if1.wb_RegWEn   = if3.wb_RegWEn;
    assign if1.load_done   = if3.load_done;
    assign if1.flush       = if3.flush;

`ifdef HAZ_PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] sc3, sc1;
`endif

    hazard_fwd_ctrl #(.REG_AW(AW), .LOAD_LAT(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (if3)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_clr     (perf_clr),
        .stall_cycles (sc3)
`endif
    );

    hazard_fwd_ctrl #(.REG_AW(AW), .LOAD_LAT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (if1)
`ifdef HAZ_PERF_CNT_EN
        ,
        .perf_clr     (perf_clr),
        .stall_cycles (sc1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_stall3(input string tag, input logic exp);
        check({tag, ".stall_if"},  32'(if3.stall_if),  32'(exp));
        check({tag, ".stall_id"},  32'(if3.stall_id),  32'(exp));
        check({tag, ".bubble_ex"}, 32'(if3.bubble_ex), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        if3.id_valid = 1'b0; if3.id_rs1 = '0; if3.id_rs2 = '0;
        if3.ex_rs1 = '0; if3.ex_rs2 = '0; if3.ex_rd = '0;
        if3.ex_RegWEn = 1'b0; if3.ex_is_load = 1'b0;
        if3.mem_rd = '0; if3.mem_RegWEn = 1'b0; if3.mem_is_load = 1'b0;
        if3.wb_rd = '0; if3.wb_RegWEn = 1'b0;
        if3.load_done = 1'b0; if3.flush = 1'b0;
    endtask

    // Load in EX writing x4, ID instruction reads x4 through rs2.
    task automatic set_hazard();
        if3.ex_is_load = 1'b1; if3.ex_RegWEn = 1'b1; if3.ex_rd = 5'd4;
        if3.id_rs2 = 5'd4; if3.id_valid = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr_in();
`ifdef HAZ_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        // Hazard and forwarding pattern present while reset is held.
        set_hazard();
        if3.ex_rs1 = 5'd5; if3.mem_rd = 5'd5; if3.mem_RegWEn = 1'b1;
        #2;
        check_stall3("rst_hold", 1'b0);
        check("rst_hold.l1_stall", 32'(if1.stall_id), 32'd0);
        check("rst_hold.fwdA", 32'(if3.ForwardSelA), 32'b10);
        step(); step();
        clr_in();
        rst_n = 1'b1;
        step();

        // MEM and WB both match rs1: MEM wins.
        if3.ex_rs1 = 5'd5; if3.mem_rd = 5'd5; if3.mem_RegWEn = 1'b1; if3.mem_is_load = 1'b0;
        if3.wb_rd = 5'd5; if3.wb_RegWEn = 1'b1;
        #1 check("fwdA_mem", 32'(if3.ForwardSelA), 32'b10);
        check("fwdB_none", 32'(if3.ForwardSelB), 32'b00);
        if3.mem_is_load = 1'b1;
        #1 check("fwdA_memload_to_wb", 32'(if3.ForwardSelA), 32'b01);
        if3.mem_is_load = 1'b0; if3.mem_RegWEn = 1'b0;
        #1 check("fwdA_memwe0_to_wb", 32'(if3.ForwardSelA), 32'b01);

        clr_in();
        if3.mem_rd = 5'd7; if3.mem_is_load = 1'b1; if3.mem_RegWEn = 1'b1;
        if3.wb_rd = 5'd7; if3.wb_RegWEn = 1'b1; if3.ex_rs2 = 5'd7;
        #1 check("fwdB_load_wb", 32'(if3.ForwardSelB), 32'b01);
        if3.mem_rd = 5'd3; if3.mem_is_load = 1'b0; if3.wb_rd = 5'd3; if3.ex_rs2 = 5'd3;
        #1 check("fwdB_mem_prio", 32'(if3.ForwardSelB), 32'b10);
        if3.mem_rd = '0; if3.wb_rd = '0; if3.ex_rs1 = '0; if3.ex_rs2 = '0;
        #1 check("fwdA_zero", 32'(if3.ForwardSelA), 32'b00);
        check("fwdB_zero", 32'(if3.ForwardSelB), 32'b00);

        // x0 destination and invalid ID never stall.
        clr_in();
        set_hazard(); if3.ex_rd = '0; if3.id_rs2 = '0;
        #1 check_stall3("x0_nostall", 1'b0);
        set_hazard(); if3.id_valid = 1'b0;
        #1 check_stall3("idinv_nostall", 1'b0);
        clr_in();
        step();

        // Full three-cycle load-use stall; the bubble removes the load from EX after cycle 1.
        set_hazard();
        #1 check_stall3("lu_c1", 1'b1);
        check("lu_c1.l1_stall", 32'(if1.stall_id), 32'd1);
        step();
        clr_in();
        #1 check_stall3("lu_c2", 1'b1);
        check("lu_c2.l1_stall", 32'(if1.stall_id), 32'd0);
        step();
        #1 check_stall3("lu_c3", 1'b1);
        step();
        #1 check_stall3("lu_done", 1'b0);
        step();

        // Early release by load_done in the second stall cycle.
        set_hazard();
        #1 check_stall3("ld_c1", 1'b1);
        step();
        clr_in(); if3.load_done = 1'b1;
        #1 check_stall3("ld_c2", 1'b0);
        step();
        if3.load_done = 1'b0;
        #1 check_stall3("ld_after", 1'b0);
        step();

        // Flush in the detect cycle: no stall and no WAIT afterwards.
        set_hazard(); if3.flush = 1'b1;
        #1 check_stall3("fl_idle", 1'b0);
        step();
        clr_in();
        #1 check_stall3("fl_idle_next", 1'b0);
        step();

        // Flush during WAIT (hazard via rs1 this time).
        set_hazard(); if3.id_rs2 = 5'd9; if3.id_rs1 = 5'd4;
        #1 check_stall3("fw_c1", 1'b1);
        step();
        clr_in();
        #1 check_stall3("fw_c2", 1'b1);
        if3.flush = 1'b1;
        #1 check_stall3("fw_flush", 1'b0);
        step();
        if3.flush = 1'b0;
        #1 check_stall3("fw_next", 1'b0);
        step();

        // Asynchronous reset mid-WAIT.
        set_hazard();
        step();
        clr_in();
        #1 check_stall3("rw_wait", 1'b1);
        rst_n = 1'b0;
        #1 check_stall3("rw_async", 1'b0);
        step();
        rst_n = 1'b1;
        #1 check_stall3("rw_release", 1'b0);
        step();
        set_hazard();
        #1 check_stall3("rw_new_c1", 1'b1);
        step();
        clr_in();
        #1 check_stall3("rw_new_c2", 1'b1);
        step(); step();
        #1 check_stall3("rw_new_done", 1'b0);

`ifdef HAZ_PERF_CNT_EN
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        #1 check("perf_cleared", sc3, 32'd0);
        for (int k = 0; k < 2; k++) begin
            set_hazard();
            step();
            clr_in();
            step(); step();
        end
        #1 check("perf_six", sc3, 32'd6);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        #1 check("perf_clr", sc3, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
